// File: rtl/spart_transmitter_if.sv
// ---------------------------------------------------------------------------
// spart_transmitter_if
//
// Purpose:
//   Groups the processor-side and serial-side signals of the SPART transmit
//   path so the transmitter and the bus logic share one bundle.
//
// Signals:
//   DATABUS   [7:0]  byte to transmit (bus -> transmitter)
//   tx_write         single-cycle write strobe (bus -> transmitter)
//   brg_en           one-clk baud tick, 16x bit rate (bus -> transmitter)
//   TX               serial line, idle high (transmitter -> bus)
//   TBR              transmit buffer ready (transmitter -> bus)
//
// Modports:
//   master  bus side, drives DATABUS/tx_write/brg_en, observes TX/TBR
//   slave   transmitter side
// ---------------------------------------------------------------------------
interface spart_transmitter_if;
  logic [7:0] DATABUS;
  logic       tx_write;
  logic       brg_en;
  logic       TX;
  logic       TBR;

  modport master (
    output DATABUS,
    output tx_write,
    output brg_en,
    input  TX,
    input  TBR
  );

  modport slave (
    input  DATABUS,
    input  tx_write,
    input  brg_en,
    output TX,
    output TBR
  );
endinterface

// File: rtl/spart_transmitter.sv
// ---------------------------------------------------------------------------
// spart_transmitter
//
// Purpose:
//   Transmit half of the SPART serial port. A byte written from the bus is
//   held in a single-entry holding register, moved into a shift register and
//   sent on TX as an 8N1 frame (start 0, 8 data bits LSB first, stop 1).
//   Bit timing is TICKS_PER_BIT pulses of the shared baud-rate enable.
//
// Parameters:
//   TICKS_PER_BIT  brg_en pulses per serial bit, legal range 2..16
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   bus.DATABUS  byte to transmit, sampled when tx_write=1 and TBR=1
//   bus.tx_write single-cycle write strobe
//   bus.brg_en   one-clk baud tick
//   bus.TX       registered serial output, idle high
//   bus.TBR      1 = holding register empty, a write will be accepted
//
// Build options:
//   SPART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                       last data bit and the stop bit (8E1 frame).
// ---------------------------------------------------------------------------
module spart_transmitter #(
  parameter int TICKS_PER_BIT = 16
) (
  input logic                clk,
  input logic                rst,
  spart_transmitter_if.slave bus
);

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SPART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic       hold_full_q, hold_full_d;
  logic       tx_q, tx_d;
  logic       bit_end;
  logic       load_frame;
`ifdef SPART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // A serial bit finishes on the edge that sees its last baud tick.
  assign bit_end = bus.brg_en && (tick_q == TICK_LAST);

  assign bus.TX  = tx_q;
  assign bus.TBR = ~hold_full_q;

  // Next-state and datapath logic. load_frame marks the edge where the
  // holding register moves into the shifter; it can never coincide with an
  // accepted write because one needs the holder full and the other empty.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    load_frame  = 1'b0;
`ifdef SPART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Baud ticks are only counted while a frame is on the line.
    if (state_q != IDLE && bus.brg_en) begin
      tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          load_frame = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef SPART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity_q;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            // Next bit on the line is what shift[0] becomes after the shift.
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef SPART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          // A byte queued during this frame starts on the very same edge,
          // so consecutive frames have no idle gap.
          if (hold_full_q) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load_frame) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tick_d      = 4'd0;
      bit_cnt_d   = 3'd0;
      state_d     = START;
      tx_d        = 1'b0;
`ifdef SPART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    // Writes while the holder is full are silently dropped.
    if (bus.tx_write && !hold_full_q) begin
      hold_d      = bus.DATABUS;
      hold_full_d = 1'b1;
    end
  end

  // State register. TX resets to 1 so the line goes high immediately with
  // no low glitch, even when reset lands in the middle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= 4'd0;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
`ifdef SPART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule
